// File: rtl/alu_pkg.sv
// Shared constants for the ALU front-end arbiter: default widths, opcodes
// and the controller state encoding.
package alu_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int OPW_DEF   = 4;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_EPAR = 4'd4;
  localparam logic [3:0] OP_CMP  = 4'd5;
  localparam logic [3:0] OP_MAX  = 4'd5;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_CAPT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

endpackage

// File: rtl/alu_arbiter_if.sv
// One requester's request/response channel into the shared ALU.
interface alu_arbiter_if #(
  parameter int WIDTH = alu_pkg::WIDTH_DEF,
  parameter int OPW   = alu_pkg::OPW_DEF
);
  logic             req_valid;
  logic             req_ready;
  logic [OPW-1:0]   req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             req_eq;
  logic [2:0]       req_ltgt;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_flag;
  logic             rsp_err;

  modport master (
    output req_valid, req_op, req_a, req_b, req_eq, req_ltgt, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_flag, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_eq, req_ltgt, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_flag, rsp_err
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer favours the port not granted last
// and only moves when a grant is actually taken.
module rr_arb2 (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);
  logic ptr;  // 1 = port 1 wins the next tie

  always_comb begin
    grant = req;
    if (req == 2'b11) grant = ptr ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                ptr <= 1'b0;
    else if (advance && |grant)  ptr <= grant[0];
  end
endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between the execute stage (port 0) and the
// debug engine (port 1): arbitrate, drive registered ALU inputs, capture, respond.
//
// state | meaning
// IDLE  | accepting requests (ready high once out of reset)
// DRIVE | ALU inputs settling
// CAPT  | sample ALU result/flag; illegal ops pass through untouched
// RESP  | response held on the granted port until rsp_ready
module alu_arbiter import alu_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int OPW   = OPW_DEF
) (
  input  logic             clock,
  input  logic             reset_n,
  alu_arbiter_if.slave     port0,
  alu_arbiter_if.slave     port1,
  output logic [OPW-1:0]   alu_op,
  output logic [WIDTH-1:0] alu_res,
  output logic [WIDTH-1:0] alu_register,
  output logic [2:0]       alu_ltgt,
  output logic             alu_eq,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_compres
);
  logic [1:0]       state;
  logic             ready_q;
  logic             sel;
  logic [WIDTH-1:0] data;
  logic             flag;
  logic             err;
  logic [1:0]       req;
  logic [1:0]       grant;
  logic             win;
  logic [OPW-1:0]   win_op;
  logic             win_illegal;
  logic             rsp_ready_sel;
  logic             rsp0_on;
  logic             rsp1_on;

  assign req = {port1.req_valid, port0.req_valid} & {2{ready_q}};

  rr_arb2 u_arb (
    .clock   (clock),
    .reset_n (reset_n),
    .req     (req),
    .advance (ready_q),
    .grant   (grant)
  );

  assign win           = grant[1];
  assign win_op        = win ? port1.req_op : port0.req_op;
  assign win_illegal   = win_op > OPW'(OP_MAX);
  assign rsp_ready_sel = sel ? port1.rsp_ready : port0.rsp_ready;

  // Illegal ops detour through CAPT so the error response lands one cycle after grant.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      ready_q      <= 1'b0;
      sel          <= 1'b0;
      data         <= '0;
      flag         <= 1'b0;
      err          <= 1'b0;
      alu_op       <= '0;
      alu_res      <= '0;
      alu_register <= '0;
      alu_ltgt     <= '0;
      alu_eq       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|grant) begin
            ready_q <= 1'b0;
            sel     <= win;
            data    <= '0;
            flag    <= 1'b0;
            err     <= win_illegal;
            if (win_illegal) begin
              state <= ST_CAPT;
            end else begin
              state        <= ST_DRIVE;
              alu_op       <= win_op;
              alu_res      <= win ? port1.req_a    : port0.req_a;
              alu_register <= win ? port1.req_b    : port0.req_b;
              alu_ltgt     <= win ? port1.req_ltgt : port0.req_ltgt;
              alu_eq       <= win ? port1.req_eq   : port0.req_eq;
            end
          end else begin
            ready_q <= 1'b1;
          end
        end
        ST_DRIVE: state <= ST_CAPT;
        ST_CAPT: begin
          if (!err) begin
            if (alu_op == OPW'(OP_CMP)) flag <= alu_compres;
            else                        data <= alu_out;
          end
          state <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready_sel) begin
            state   <= ST_IDLE;
            ready_q <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign rsp0_on = (state == ST_RESP) && !sel;
  assign rsp1_on = (state == ST_RESP) &&  sel;

  assign port0.req_ready = ready_q;
  assign port1.req_ready = ready_q;
  assign port0.rsp_valid = rsp0_on;
  assign port1.rsp_valid = rsp1_on;
  assign port0.rsp_data  = rsp0_on ? data : '0;
  assign port1.rsp_data  = rsp1_on ? data : '0;
  assign port0.rsp_flag  = rsp0_on & flag;
  assign port1.rsp_flag  = rsp1_on & flag;
  assign port0.rsp_err   = rsp0_on & err;
  assign port1.rsp_err   = rsp1_on & err;
endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: the bench plays both requesters and the ALU.
module tb_alu_arbiter;
  logic        clock;
  logic        reset_n;
  logic [3:0]  alu_op;
  logic [15:0] alu_res;
  logic [15:0] alu_register;
  logic [2:0]  alu_ltgt;
  logic        alu_eq;
  logic [15:0] alu_out;
  logic        alu_compres;

  int n_checks = 0;
  int n_fail   = 0;

  alu_arbiter_if p0 ();
  alu_arbiter_if p1 ();

  alu_arbiter dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .port0        (p0),
    .port1        (p1),
    .alu_op       (alu_op),
    .alu_res      (alu_res),
    .alu_register (alu_register),
    .alu_ltgt     (alu_ltgt),
    .alu_eq       (alu_eq),
    .alu_out      (alu_out),
    .alu_compres  (alu_compres)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference ALU semantics used both to play the ALU and to predict responses.
  function automatic logic [15:0] alu_fn(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return {15'b0, ^a};
      default: return 16'h0;
    endcase
  endfunction

  function automatic logic cmp_fn(input logic [15:0] a, input logic [15:0] b, input logic eq, input logic [2:0] ltgt);
    if (eq) return a == b;
    case (ltgt)
      3'd1:    return a < b;
      3'd2:    return a > b;
      default: return 1'b0;
    endcase
  endfunction

  always_comb begin
    alu_out     = alu_fn(alu_op, alu_res, alu_register);
    alu_compres = cmp_fn(alu_res, alu_register, alu_eq, alu_ltgt);
  end

  wire [79:0] all_out = {p0.req_ready, p1.req_ready, p0.rsp_valid, p1.rsp_valid,
                         p0.rsp_data, p1.rsp_data, p0.rsp_flag, p1.rsp_flag,
                         p0.rsp_err, p1.rsp_err, alu_op, alu_res, alu_register,
                         alu_ltgt, alu_eq};

  task automatic set_req(input int port, input logic v, input logic [3:0] op,
                         input logic [15:0] a, input logic [15:0] b,
                         input logic eq, input logic [2:0] ltgt);
    if (port == 0) begin
      p0.req_valid = v; p0.req_op = op; p0.req_a = a; p0.req_b = b; p0.req_eq = eq; p0.req_ltgt = ltgt;
    end else begin
      p1.req_valid = v; p1.req_op = op; p1.req_a = a; p1.req_b = b; p1.req_eq = eq; p1.req_ltgt = ltgt;
    end
  endtask

  task automatic set_rsp_ready(input int port, input logic v);
    if (port == 0) p0.rsp_ready = v;
    else           p1.rsp_ready = v;
  endtask

  function automatic logic rsp_valid_of(input int port);
    return (port == 0) ? p0.rsp_valid : p1.rsp_valid;
  endfunction

  function automatic logic [17:0] rsp_of(input int port);
    return (port == 0) ? {p0.rsp_data, p0.rsp_flag, p0.rsp_err} : {p1.rsp_data, p1.rsp_flag, p1.rsp_err};
  endfunction

  // Present one request, wait for its response, check it, then complete the handshake.
  task automatic run_one(input int port, input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic eq, input logic [2:0] ltgt,
                         input int hold, input int exp_lat, input string name);
    logic [15:0] exp_data;
    logic        exp_flag;
    logic        exp_err;
    int          cycles;
    bit          seen;
    exp_err  = (op > 4'd5);
    exp_data = (exp_err || op == 4'd5) ? 16'h0 : alu_fn(op, a, b);
    exp_flag = (op == 4'd5) ? cmp_fn(a, b, eq, ltgt) : 1'b0;
    @(posedge clock); #1;
    set_rsp_ready(port, hold == 0);
    set_req(port, 1'b1, op, a, b, eq, ltgt);
    cycles = 0;
    seen   = 0;
    while (!seen && cycles < 40) begin
      @(posedge clock);
      cycles++;
      @(negedge clock);
      seen = rsp_valid_of(port);
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s timeout: no rsp_valid on port %0d after %0d cycles, required within 40", name, port, cycles);
      set_rsp_ready(port, 1'b1);
      set_req(port, 1'b0, op, a, b, eq, ltgt);
      return;
    end
    if (exp_lat >= 0) begin
      n_checks++;
      if (cycles !== exp_lat) begin
        n_fail++;
        $display("FAIL %s latency: got %0d cycles, required %0d", name, cycles, exp_lat);
      end
    end
    n_checks++;
    if (rsp_of(port) !== {exp_data, exp_flag, exp_err}) begin
      n_fail++;
      $display("FAIL %s response: got data=%h flag=%b err=%b, required data=%h flag=%b err=%b",
               name, rsp_of(port)[17:2], rsp_of(port)[1], rsp_of(port)[0], exp_data, exp_flag, exp_err);
    end
    n_checks++;
    if (rsp_valid_of(1 - port) !== 1'b0) begin
      n_fail++;
      $display("FAIL %s other_port_valid: got 1, required 0", name);
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clock);
      @(negedge clock);
      n_checks++;
      if (rsp_valid_of(port) !== 1'b1 || rsp_of(port) !== {exp_data, exp_flag, exp_err} ||
          p0.req_ready !== 1'b0 || p1.req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL %s backpressure hold %0d: got valid=%b rsp=%h ready0=%b ready1=%b, required valid=1 rsp=%h ready0=0 ready1=0",
                 name, h, rsp_valid_of(port), rsp_of(port), p0.req_ready, p1.req_ready, {exp_data, exp_flag, exp_err});
      end
    end
    set_rsp_ready(port, 1'b1);
    @(posedge clock); #1;
    set_req(port, 1'b0, op, a, b, eq, ltgt);
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if (all_out !== 80'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, required 0", all_out);
    end
    @(posedge clock); #1;
    n_checks++;
    if (all_out !== 80'h0) begin
      n_fail++;
      $display("FAIL reset_held_over_edge: got %h, required 0", all_out);
    end
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
    n_checks++;
    if ({p0.req_ready, p1.req_ready, p0.rsp_valid, p1.rsp_valid} !== 4'b1100) begin
      n_fail++;
      $display("FAIL reset_idle_ready: got ready/valid=%b, required 1100",
               {p0.req_ready, p1.req_ready, p0.rsp_valid, p1.rsp_valid});
    end
  endtask

  task automatic test_tie();
    fork
      run_one(0, 4'd1, 16'd10, 16'd3, 1'b0, 3'd0, 0, 3, "tie1_port0");
      run_one(1, 4'd3, 16'h00F0, 16'h000F, 1'b0, 3'd0, 0, 7, "tie1_port1");
    join
    run_one(0, 4'd2, 16'hF0F0, 16'h3C3C, 1'b0, 3'd0, 0, 3, "tie_prime_port0");
    fork
      run_one(0, 4'd0, 16'd100, 16'd23, 1'b0, 3'd0, 0, 7, "tie2_port0");
      run_one(1, 4'd1, 16'd5, 16'd9, 1'b0, 3'd0, 0, 3, "tie2_port1");
    join
  endtask

  task automatic test_single();
    run_one(0, 4'd0, 16'd7, 16'd5, 1'b0, 3'd0, 0, 3, "single_add");
  endtask

  task automatic test_cmp_epar();
    run_one(1, 4'd5, 16'd4, 16'd9, 1'b0, 3'd1, 0, 3, "cmp_lt");
    run_one(1, 4'd4, 16'h0007, 16'h0000, 1'b0, 3'd0, 0, 3, "epar");
  endtask

  task automatic test_illegal();
    logic [38:0] saved;
    saved = {alu_op, alu_res, alu_register, alu_ltgt, alu_eq};
    run_one(0, 4'd7, 16'h1234, 16'h5678, 1'b1, 3'd2, 0, 2, "illegal_op");
    n_checks++;
    if ({alu_op, alu_res, alu_register, alu_ltgt, alu_eq} !== saved) begin
      n_fail++;
      $display("FAIL illegal_alu_unchanged: got %h, required %h",
               {alu_op, alu_res, alu_register, alu_ltgt, alu_eq}, saved);
    end
  endtask

  task automatic test_backpressure();
    fork
      run_one(0, 4'd0, 16'h1111, 16'h2222, 1'b0, 3'd0, 5, 3, "bp_port0");
      begin
        repeat (2) @(posedge clock);
        run_one(1, 4'd3, 16'hA000, 16'h000A, 1'b0, 3'd0, 0, 10, "bp_port1");
      end
    join
  endtask

  task automatic test_async_reset();
    @(posedge clock); #1;
    set_rsp_ready(0, 1'b1);
    set_rsp_ready(1, 1'b1);
    set_req(0, 1'b1, 4'd0, 16'd3, 16'd4, 1'b0, 3'd0);
    @(posedge clock); #2;
    n_checks++;
    if (alu_res !== 16'd3) begin
      n_fail++;
      $display("FAIL arst_drive_loaded: got alu_res=%h, required 0003", alu_res);
    end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (all_out !== 80'h0) begin
      n_fail++;
      $display("FAIL arst_immediate: got %h, required 0", all_out);
    end
    set_req(0, 1'b0, 4'd0, 16'd3, 16'd4, 1'b0, 3'd0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clock);
      n_checks++;
      if ({p0.rsp_valid, p1.rsp_valid} !== 2'b00) begin
        n_fail++;
        $display("FAIL arst_dropped_response: got valid=%b, required 00", {p0.rsp_valid, p1.rsp_valid});
      end
    end
    fork
      run_one(0, 4'd2, 16'h0FF0, 16'h00FF, 1'b0, 3'd0, 0, 3, "arst_tie_port0");
      run_one(1, 4'd0, 16'd1, 16'd2, 1'b0, 3'd0, 0, 7, "arst_tie_port1");
    join
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      int          port;
      logic [3:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic        eq;
      logic [2:0]  ltgt;
      int          hold;
      port = $urandom_range(0, 1);
      op   = 4'($urandom_range(0, 7));
      a    = 16'($urandom);
      b    = (($urandom & 3) == 0) ? a : 16'($urandom);
      eq   = 1'($urandom);
      ltgt = 3'($urandom_range(0, 4));
      hold = $urandom_range(0, 3);
      run_one(port, op, a, b, eq, ltgt, hold, (op > 4'd5) ? 2 : 3, "random");
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, required the run to finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    set_req(0, 1'b0, 4'd0, 16'd0, 16'd0, 1'b0, 3'd0);
    set_req(1, 1'b0, 4'd0, 16'd0, 16'd0, 1'b0, 3'd0);
    set_rsp_ready(0, 1'b1);
    set_rsp_ready(1, 1'b1);
    test_reset();
    test_tie();
    test_single();
    test_cmp_epar();
    test_illegal();
    test_backpressure();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
